// File: rtl/control_pipe.sv
// rtl/control_pipe.sv - registered RV32I/M control decoder with valid/ready handshake and mul/div stall
module control_pipe #(
  parameter int M_EXT       = 1,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 32,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush_i,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  output logic        instr_ready_o,
  output logic        ctl_valid_o,
  input  logic        ctl_ready_i,
  output logic [1:0]  pc_sel_o,
  output logic        op1sel_o,
  output logic [1:0]  op2sel_o,
  output logic [1:0]  wb_sel_o,
  output logic [5:0]  alu_fun_o,
  output logic [2:0]  br_fun_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic [1:0]  mem_size_o,
  output logic        mem_uns_o,
  output logic        rf_en_o,
  output logic        md_start_o,
  output logic [2:0]  md_op_o,
  output logic        illegal_o
);

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_FULL = 2'd1, S_MD_WAIT = 2'd2} state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic             r_md_start;
  logic [1:0]       r_pc_sel;
  logic             r_op1sel;
  logic [1:0]       r_op2sel;
  logic [1:0]       r_wb_sel;
  logic [5:0]       r_alu_fun;
  logic [2:0]       r_br_fun;
  logic             r_mem_rd;
  logic             r_mem_wr;
  logic [1:0]       r_mem_size;
  logic             r_mem_uns;
  logic             r_rf_en;
  logic [2:0]       r_md_op;
  logic             r_illegal;

  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic [6:0]       w_funct7;
  logic             w_accept;
  logic [1:0]       w_pc_sel;
  logic             w_op1sel;
  logic [1:0]       w_op2sel;
  logic [1:0]       w_wb_sel;
  logic [5:0]       w_alu_fun;
  logic [2:0]       w_br_fun;
  logic             w_mem_rd;
  logic             w_mem_wr;
  logic [1:0]       w_mem_size;
  logic             w_mem_uns;
  logic             w_rf_en;
  logic             w_md;
  logic [2:0]       w_md_op;
  logic             w_legal;
  logic             w_illegal;
  logic [CNT_W-1:0] w_md_load;
  logic             w_unused_fields;

  assign w_opcode        = instr_i[6:0];
  assign w_funct3        = instr_i[14:12];
  assign w_funct7        = instr_i[31:25];
  assign w_unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  function automatic logic [5:0] alu_code(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_code = alt ? 6'b000001 : 6'b000000;
      3'b001:  alu_code = 6'b000010;
      3'b010:  alu_code = 6'b101001;
      3'b011:  alu_code = 6'b110001;
      3'b100:  alu_code = 6'b100000;
      3'b101:  alu_code = alt ? 6'b000110 : 6'b000100;
      3'b110:  alu_code = 6'b001000;
      default: alu_code = 6'b010000;
    endcase
  endfunction

  always_comb begin
    w_pc_sel   = 2'b00;
    w_op1sel   = 1'b0;
    w_op2sel   = 2'b00;
    w_wb_sel   = 2'b00;
    w_alu_fun  = 6'b000000;
    w_br_fun   = 3'b000;
    w_mem_rd   = 1'b0;
    w_mem_wr   = 1'b0;
    w_mem_size = 2'b00;
    w_mem_uns  = 1'b0;
    w_rf_en    = 1'b0;
    w_md       = 1'b0;
    w_md_op    = 3'b000;
    w_legal    = 1'b1;
    case (w_opcode)
      7'b0110111: begin
        w_op2sel = 2'b10; w_wb_sel = 2'b01; w_rf_en = 1'b1;
      end
      7'b0010111: begin
        w_op1sel = 1'b1; w_op2sel = 2'b10; w_wb_sel = 2'b01; w_rf_en = 1'b1;
      end
      7'b1101111: begin
        w_pc_sel = 2'b01; w_op1sel = 1'b1; w_wb_sel = 2'b11; w_rf_en = 1'b1;
      end
      7'b1100111: begin
        w_pc_sel = 2'b10; w_op2sel = 2'b01; w_wb_sel = 2'b11; w_rf_en = 1'b1;
      end
      7'b1100011: begin
        w_legal  = (w_funct3[2:1] != 2'b01);
        w_pc_sel = 2'b01; w_op2sel = 2'b11; w_br_fun = w_funct3;
      end
      7'b0000011: begin
        w_legal    = (w_funct3 != 3'b011) && (w_funct3[2:1] != 2'b11);
        w_op2sel   = 2'b01; w_wb_sel = 2'b00; w_mem_rd = 1'b1; w_rf_en = 1'b1;
        w_mem_size = w_funct3[1:0]; w_mem_uns = w_funct3[2];
      end
      7'b0100011: begin
        w_legal    = (w_funct3 < 3'b011);
        w_op2sel   = 2'b01; w_mem_wr = 1'b1; w_mem_size = w_funct3[1:0];
      end
      7'b0010011: begin
        w_op2sel = 2'b01; w_wb_sel = 2'b01; w_rf_en = 1'b1;
        w_alu_fun = alu_code(w_funct3, (w_funct3 == 3'b101) && (w_funct7 == 7'b0100000));
        if (w_funct3 == 3'b001)
          w_legal = (w_funct7 == 7'b0000000);
        else if (w_funct3 == 3'b101)
          w_legal = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
      end
      7'b0110011: begin
        w_op2sel = 2'b11; w_rf_en = 1'b1;
        if (w_funct7 == 7'b0000001) begin
          w_legal  = (M_EXT != 0);
          w_md     = (M_EXT != 0);
          w_wb_sel = 2'b10;
          w_md_op  = w_funct3;
        end else begin
          w_wb_sel  = 2'b01;
          w_alu_fun = alu_code(w_funct3, w_funct7 == 7'b0100000);
          w_legal   = (w_funct7 == 7'b0000000) ||
                      ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
        end
      end
      default: w_legal = 1'b0;
    endcase
    w_illegal = !w_legal;
    // An illegal word still travels as a bundle, but carries no side effects.
    if (!w_legal) begin
      w_pc_sel = 2'b00; w_op1sel = 1'b0; w_op2sel = 2'b00; w_wb_sel = 2'b00;
      w_alu_fun = 6'b000000; w_br_fun = 3'b000; w_mem_rd = 1'b0; w_mem_wr = 1'b0;
      w_mem_size = 2'b00; w_mem_uns = 1'b0; w_rf_en = 1'b0; w_md = 1'b0; w_md_op = 3'b000;
    end
  end

  assign w_md_load     = w_funct3[2] ? DIV_LOAD : MUL_LOAD;
  assign instr_ready_o = !flush_i && ((r_state == S_EMPTY) || ((r_state == S_FULL) && ctl_ready_i));
  assign w_accept      = instr_valid_i && instr_ready_o;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_EMPTY;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_md_start <= 1'b0;
      r_pc_sel   <= 2'b00;
      r_op1sel   <= 1'b0;
      r_op2sel   <= 2'b00;
      r_wb_sel   <= 2'b00;
      r_alu_fun  <= 6'b000000;
      r_br_fun   <= 3'b000;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_size <= 2'b00;
      r_mem_uns  <= 1'b0;
      r_rf_en    <= 1'b0;
      r_md_op    <= 3'b000;
      r_illegal  <= 1'b0;
    end else if (flush_i) begin
      r_state    <= S_EMPTY;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_md_start <= 1'b0;
    end else begin
      r_md_start <= 1'b0;
      if (w_accept) begin
        r_pc_sel   <= w_pc_sel;
        r_op1sel   <= w_op1sel;
        r_op2sel   <= w_op2sel;
        r_wb_sel   <= w_wb_sel;
        r_alu_fun  <= w_alu_fun;
        r_br_fun   <= w_br_fun;
        r_mem_rd   <= w_mem_rd;
        r_mem_wr   <= w_mem_wr;
        r_mem_size <= w_mem_size;
        r_mem_uns  <= w_mem_uns;
        r_rf_en    <= w_rf_en;
        r_md_op    <= w_md_op;
        r_illegal  <= w_illegal;
        if (w_md) begin
          r_state    <= S_MD_WAIT;
          r_valid    <= 1'b0;
          r_md_start <= 1'b1;
          r_cnt      <= w_md_load;
        end else begin
          r_state <= S_FULL;
          r_valid <= 1'b1;
        end
      end else begin
        case (r_state)
          S_FULL: begin
            if (ctl_ready_i) begin
              r_state <= S_EMPTY;
              r_valid <= 1'b0;
            end
          end
          S_MD_WAIT: begin
            if (r_cnt == '0) begin
              r_state <= S_FULL;
              r_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ctl_valid_o = r_valid;
  assign md_start_o  = r_md_start;
  assign pc_sel_o    = r_pc_sel;
  assign op1sel_o    = r_op1sel;
  assign op2sel_o    = r_op2sel;
  assign wb_sel_o    = r_wb_sel;
  assign alu_fun_o   = r_alu_fun;
  assign br_fun_o    = r_br_fun;
  assign mem_size_o  = r_mem_size;
  assign mem_uns_o   = r_mem_uns;
  assign md_op_o     = r_md_op;
  assign illegal_o   = r_illegal;
  assign rf_en_o     = r_rf_en  & r_valid;
  assign mem_rd_o    = r_mem_rd & r_valid;
  assign mem_wr_o    = r_mem_wr & r_valid;

endmodule

// File: tb/tb_control_pipe.sv
// tb/tb_control_pipe.sv - directed and randomized bench for control_pipe against a transaction-level model
module tb_control_pipe;

  localparam int MUL_L = 2;
  localparam int DIV_L = 32;

  localparam logic [31:0] I_ADD = 32'h003100B3;
  localparam logic [31:0] I_SUB = 32'h403100B3;
  localparam logic [31:0] I_LW  = 32'h00012083;
  localparam logic [31:0] I_DIV = 32'h023140B3;
  localparam logic [31:0] I_MUL = 32'h023100B3;
  localparam logic [31:0] I_BAD = 32'hFFFFFFFF;

  typedef struct packed {
    logic [1:0] pc;
    logic       op1;
    logic [1:0] op2;
    logic [1:0] wb;
    logic [5:0] alu;
    logic [2:0] br;
    logic       rd;
    logic       wr;
    logic [1:0] sz;
    logic       uns;
    logic       rf;
    logic [2:0] md;
    logic       ill;
  } bundle_t;

  logic        clk, reset_n, flush_i, instr_valid_i, ctl_ready_i;
  logic [31:0] instr_i;
  logic        instr_ready_o, ctl_valid_o, md_start_o;
  logic [1:0]  pc_sel_o, op2sel_o, wb_sel_o, mem_size_o;
  logic        op1sel_o, mem_rd_o, mem_wr_o, mem_uns_o, rf_en_o, illegal_o;
  logic [5:0]  alu_fun_o;
  logic [2:0]  br_fun_o, md_op_o;

  logic        d0_ready, d0_valid, d0_md_start;
  logic [1:0]  d0_pc_sel, d0_op2sel, d0_wb_sel, d0_mem_size;
  logic        d0_op1sel, d0_mem_rd, d0_mem_wr, d0_mem_uns, d0_rf_en, d0_illegal;
  logic [5:0]  d0_alu_fun;
  logic [2:0]  d0_br_fun, d0_md_op;

  bundle_t obs_b, d0_b;
  assign obs_b = {pc_sel_o, op1sel_o, op2sel_o, wb_sel_o, alu_fun_o, br_fun_o, mem_rd_o, mem_wr_o,
                  mem_size_o, mem_uns_o, rf_en_o, md_op_o, illegal_o};
  assign d0_b  = {d0_pc_sel, d0_op1sel, d0_op2sel, d0_wb_sel, d0_alu_fun, d0_br_fun, d0_mem_rd, d0_mem_wr,
                  d0_mem_size, d0_mem_uns, d0_rf_en, d0_md_op, d0_illegal};

  control_pipe #(.M_EXT(1), .MUL_LATENCY(MUL_L), .DIV_LATENCY(DIV_L), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .instr_valid_i(instr_valid_i), .instr_i(instr_i),
    .instr_ready_o(instr_ready_o), .ctl_valid_o(ctl_valid_o), .ctl_ready_i(ctl_ready_i),
    .pc_sel_o(pc_sel_o), .op1sel_o(op1sel_o), .op2sel_o(op2sel_o), .wb_sel_o(wb_sel_o),
    .alu_fun_o(alu_fun_o), .br_fun_o(br_fun_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
    .mem_size_o(mem_size_o), .mem_uns_o(mem_uns_o), .rf_en_o(rf_en_o), .md_start_o(md_start_o),
    .md_op_o(md_op_o), .illegal_o(illegal_o)
  );

  control_pipe #(.M_EXT(0), .MUL_LATENCY(MUL_L), .DIV_LATENCY(DIV_L), .CNT_W(6)) dut0 (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .instr_valid_i(instr_valid_i), .instr_i(instr_i),
    .instr_ready_o(d0_ready), .ctl_valid_o(d0_valid), .ctl_ready_i(ctl_ready_i),
    .pc_sel_o(d0_pc_sel), .op1sel_o(d0_op1sel), .op2sel_o(d0_op2sel), .wb_sel_o(d0_wb_sel),
    .alu_fun_o(d0_alu_fun), .br_fun_o(d0_br_fun), .mem_rd_o(d0_mem_rd), .mem_wr_o(d0_mem_wr),
    .mem_size_o(d0_mem_size), .mem_uns_o(d0_mem_uns), .rf_en_o(d0_rf_en), .md_start_o(d0_md_start),
    .md_op_o(d0_md_op), .illegal_o(d0_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      n_checks = 0;
  int      n_errors = 0;
  int      cyc = 0;
  int      k;
  int      seen;
  bit      m_full = 1'b0;
  bit      m_md = 1'b0;
  int      m_ready_at = 0;
  bundle_t m_b = '0;
  bit      dummy_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bundle_t ref_decode(input logic [31:0] ins, input bit mext, output bit is_m);
    logic [5:0] alu_tab [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         legal;
    bundle_t    b;
    alu_tab = '{6'b000000, 6'b000010, 6'b101001, 6'b110001, 6'b100000, 6'b000100, 6'b001000, 6'b010000};
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    b = '0; legal = 1'b1; is_m = 1'b0;
    case (opc)
      7'h37: begin b.op2 = 2'd2; b.wb = 2'd1; b.rf = 1'b1; end
      7'h17: begin b.op1 = 1'b1; b.op2 = 2'd2; b.wb = 2'd1; b.rf = 1'b1; end
      7'h6F: begin b.pc = 2'd1; b.op1 = 1'b1; b.wb = 2'd3; b.rf = 1'b1; end
      7'h67: begin b.pc = 2'd2; b.op2 = 2'd1; b.wb = 2'd3; b.rf = 1'b1; end
      7'h63: begin
        legal = !(f3 inside {3'd2, 3'd3});
        b.pc = 2'd1; b.op2 = 2'd3; b.br = f3;
      end
      7'h03: begin
        legal = !(f3 inside {3'd3, 3'd6, 3'd7});
        b.op2 = 2'd1; b.rd = 1'b1; b.sz = f3[1:0]; b.uns = f3[2]; b.rf = 1'b1;
      end
      7'h23: begin
        legal = (f3 <= 3'd2);
        b.op2 = 2'd1; b.wr = 1'b1; b.sz = f3[1:0];
      end
      7'h13: begin
        b.op2 = 2'd1; b.wb = 2'd1; b.rf = 1'b1; b.alu = alu_tab[f3];
        if (f3 == 3'd1) legal = (f7 == 7'h00);
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) b.alu = 6'b000110;
          else legal = (f7 == 7'h00);
        end
      end
      7'h33: begin
        b.op2 = 2'd3; b.rf = 1'b1;
        if (f7 == 7'h01) begin
          legal = mext; is_m = mext; b.wb = 2'd2; b.md = f3;
        end else begin
          b.wb = 2'd1; b.alu = alu_tab[f3];
          if (f7 == 7'h20 && f3 == 3'd0) b.alu = 6'b000001;
          else if (f7 == 7'h20 && f3 == 3'd5) b.alu = 6'b000110;
          else legal = (f7 == 7'h00);
        end
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      b = '0; b.ill = 1'b1; is_m = 1'b0;
    end
    return b;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    r = $urandom;
    case ($urandom_range(0, 11))
      0: opc = 7'h37;  1: opc = 7'h17;  2: opc = 7'h6F;  3: opc = 7'h67;
      4: opc = 7'h63;  5: opc = 7'h03;  6: opc = 7'h23;  7: opc = 7'h13;
      8, 9, 10: opc = 7'h33;
      default: opc = r[6:0];
    endcase
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;  1: f7 = 7'h20;  2: f7 = 7'h01;
      default: f7 = r[31:25];
    endcase
    f3 = 3'($urandom_range(0, 7));
    return {f7, r[24:15], f3, r[11:7], opc};
  endfunction

  // One clock: drive, check the combinational ready, advance the model, check the registered outputs.
  task automatic tick(input logic v, input logic [31:0] ins, input logic rdy, input logic fl, input logic rn);
    logic    vis, exp_rdy;
    bit      ism;
    bundle_t nb, eb;
    int      lat;
    instr_valid_i = v; instr_i = ins; ctl_ready_i = rdy; flush_i = fl; reset_n = rn;
    #1;
    vis     = m_full && (cyc >= m_ready_at);
    exp_rdy = !fl && (!m_full || (vis && rdy));
    if (rn) chk("instr_ready", 32'(instr_ready_o), 32'(exp_rdy));
    nb  = ref_decode(ins, 1'b1, ism);
    lat = ins[14] ? DIV_L : MUL_L;
    @(posedge clk);
    #1;
    cyc++;
    if (!rn) begin
      m_full = 1'b0; m_md = 1'b0; m_b = '0;
    end else if (fl) begin
      m_full = 1'b0; m_md = 1'b0;
    end else begin
      m_md = 1'b0;
      if (vis && rdy) m_full = 1'b0;
      if (v && exp_rdy) begin
        m_full = 1'b1; m_b = nb; m_md = ism;
        m_ready_at = cyc + (ism ? lat : 0);
      end
    end
    vis = m_full && (cyc >= m_ready_at);
    eb  = m_b;
    if (!vis) begin
      eb.rd = 1'b0; eb.wr = 1'b0; eb.rf = 1'b0;
    end
    chk("ctl_valid", 32'(ctl_valid_o), 32'(vis));
    chk("md_start", 32'(md_start_o), 32'(m_md));
    chk("bundle", 32'(obs_b), 32'(eb));
  endtask

  initial begin
    repeat (2) tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("reset_valid", 32'(ctl_valid_o), 32'd0);
    chk("reset_bundle", 32'(obs_b), 32'd0);
    chk("reset_ready", 32'(instr_ready_o), 32'd1);

    tick(1'b1, I_ADD, 1'b1, 1'b0, 1'b1);
    chk("add_alu", 32'(alu_fun_o), 32'h00);
    chk("add_op2", 32'(op2sel_o), 32'd3);
    chk("add_wb", 32'(wb_sel_o), 32'd1);
    chk("add_rf", 32'(rf_en_o), 32'd1);
    tick(1'b1, I_SUB, 1'b1, 1'b0, 1'b1);
    chk("sub_alu", 32'(alu_fun_o), 32'h01);
    chk("sub_valid", 32'(ctl_valid_o), 32'd1);
    chk("b2b_ready", 32'(instr_ready_o), 32'd1);
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

    tick(1'b1, I_LW, 1'b0, 1'b0, 1'b1);
    chk("lw_rd", 32'(mem_rd_o), 32'd1);
    chk("lw_size", 32'(mem_size_o), 32'd2);
    chk("lw_wb", 32'(wb_sel_o), 32'd0);
    repeat (4) begin
      tick(1'b1, I_ADD, 1'b0, 1'b0, 1'b1);
      chk("lw_stall_ready", 32'(instr_ready_o), 32'd0);
      chk("lw_hold_rd", 32'(mem_rd_o), 32'd1);
    end
    tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

    tick(1'b1, I_DIV, 1'b1, 1'b0, 1'b1);
    chk("div_pre_rst_start", 32'(md_start_o), 32'd1);
    repeat (5) tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    repeat (3) tick(1'b1, I_ADD, 1'b1, 1'b1, 1'b0);
    chk("midrst_valid", 32'(ctl_valid_o), 32'd0);
    chk("midrst_bundle", 32'(obs_b), 32'd0);

    tick(1'b1, I_DIV, 1'b1, 1'b0, 1'b1);
    chk("div_start", 32'(md_start_o), 32'd1);
    chk("m0_valid", 32'(d0_valid), 32'd1);
    chk("m0_bundle", 32'(d0_b), 32'(ref_decode(I_DIV, 1'b0, dummy_m)));
    chk("m0_illegal", 32'(d0_illegal), 32'd1);
    chk("m0_no_start", 32'(d0_md_start), 32'd0);
    chk("m0_ready", 32'(d0_ready), 32'd1);
    k = 0;
    do begin
      tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      k++;
    end while (!ctl_valid_o && k < 40);
    chk("div_latency", 32'(k), 32'(DIV_L));
    chk("div_wb", 32'(wb_sel_o), 32'd2);
    chk("div_md_op", 32'(md_op_o), 32'd4);

    tick(1'b1, I_MUL, 1'b1, 1'b0, 1'b1);
    chk("mul_start", 32'(md_start_o), 32'd1);
    k = 0;
    do begin
      tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      k++;
    end while (!ctl_valid_o && k < 40);
    chk("mul_latency", 32'(k), 32'(MUL_L));

    tick(1'b1, I_BAD, 1'b1, 1'b0, 1'b1);
    chk("bad_valid", 32'(ctl_valid_o), 32'd1);
    chk("bad_illegal", 32'(illegal_o), 32'd1);
    chk("bad_rf", 32'(rf_en_o), 32'd0);
    chk("bad_wr", 32'(mem_wr_o), 32'd0);

    tick(1'b1, I_DIV, 1'b1, 1'b0, 1'b1);
    repeat (9) tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    tick(1'b1, I_ADD, 1'b1, 1'b1, 1'b1);
    seen = 0;
    repeat (40) begin
      tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      if (ctl_valid_o) seen++;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    tick(1'b1, I_ADD, 1'b1, 1'b0, 1'b1);
    chk("post_flush_valid", 32'(ctl_valid_o), 32'd1);
    chk("post_flush_alu", 32'(alu_fun_o), 32'h00);

    repeat (1500)
      tick($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 49) == 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
